// File: rtl/conv1_buf_pkg.sv
// conv1_buf_pkg
// Shared geometry for the conv1 window generator: image size, kernel size,
// derived output-map size and the counter widths used to walk a frame.
package conv1_buf_pkg;

    localparam int IMG_W             = 28;
    localparam int IMG_H             = 28;
    localparam int KERNEL_SIZE       = 3;
    localparam int WINDOW_SIZE       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int OUT_W             = IMG_W - KERNEL_SIZE + 1;
    localparam int OUT_H             = IMG_H - KERNEL_SIZE + 1;
    localparam int WINDOWS_PER_FRAME = OUT_W * OUT_H;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    // Sized coordinate constants so counter compares stay width-exact.
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(KERNEL_SIZE - 1);

    // win[i][j]: row i (0 = oldest image row), column j (2 = newest pixel).
    typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

endpackage

// File: rtl/conv1_line_shift.sv
// conv1_line_shift
// One image row of 1-bit pixel history. Each enabled cycle shifts din in;
// dout is the bit shifted in DEPTH enables ago, i.e. the same column of the
// previous row when DEPTH equals the image width.
// Ports:
//   clk  - rising-edge clock
//   en   - shift enable (one accepted pixel)
//   din  - bit shifted in
//   dout - oldest stored bit
module conv1_line_shift
    import conv1_buf_pkg::*;
#(
    parameter int DEPTH = IMG_W
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] line_bits;

    // No reset: stale contents are masked by the row gating in conv1_buf.
    always_ff @(posedge clk) begin
        if (en) begin
            line_bits <= {line_bits[DEPTH-2:0], din};
        end
    end

    assign dout = line_bits[DEPTH-1];

endmodule

// File: rtl/conv1_buf.sv
// conv1_buf
// 3x3 sliding-window generator for a raster stream of binarized pixels.
// Two line buffers hold the previous two rows; a 3x3 register forms the
// window, emitted with a one-cycle strobe whenever the accepted pixel
// completes a full window (row >= 2 and col >= 2).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   valid_in, pixel_in  - input pixel stream (raster order)
//   pixel_0..pixel_8    - window taps, pixel_k = frame(r-2+k/3, c-2+k%3)
//   valid_in_buf        - taps valid this cycle
//   frame_done          - pulse with the last window of a frame
module conv1_buf
    import conv1_buf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic pixel_in,
    output logic pixel_0,
    output logic pixel_1,
    output logic pixel_2,
    output logic pixel_3,
    output logic pixel_4,
    output logic pixel_5,
    output logic pixel_6,
    output logic pixel_7,
    output logic pixel_8,
    output logic valid_in_buf,
    output logic frame_done
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             line_a_out;
    logic             line_b_out;
    window_t          win;

    // A pixel presented during reset is ignored, so lines stay frozen too.
    assign accept = valid_in & rst_n;

    conv1_line_shift #(
        .DEPTH(IMG_W)
    ) u_line_a (
        .clk  (clk),
        .en   (accept),
        .din  (pixel_in),
        .dout (line_a_out)
    );

    conv1_line_shift #(
        .DEPTH(IMG_W)
    ) u_line_b (
        .clk  (clk),
        .en   (accept),
        .din  (line_a_out),
        .dout (line_b_out)
    );

    // Coordinate of the next accepted pixel; frame end wraps straight to (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The window register doubles as the tap outputs, so taps hold through gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win <= '0;
        end else if (valid_in) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
            end
            win[0][KERNEL_SIZE-1] <= line_b_out;
            win[1][KERNEL_SIZE-1] <= line_a_out;
            win[2][KERNEL_SIZE-1] <= pixel_in;
        end
    end

    // Row gating also guarantees stale line contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_in_buf <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            valid_in_buf <= valid_in && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
            frame_done   <= valid_in && (row == ROW_LAST) && (col == COL_LAST);
        end
    end

    assign pixel_0 = win[0][0];
    assign pixel_1 = win[0][1];
    assign pixel_2 = win[0][2];
    assign pixel_3 = win[1][0];
    assign pixel_4 = win[1][1];
    assign pixel_5 = win[1][2];
    assign pixel_6 = win[2][0];
    assign pixel_7 = win[2][1];
    assign pixel_8 = win[2][2];

endmodule
